scan_code_event_ctrl: RTL and testbench
=======================================

// Module: scan_code_event_ctrl
// PURPOSE
//  Sequences the raw byte stream from ScanCodeModule (NewScanCode/ScanCode) into
//  key events. Strips the E0 (extended) and F0 (break) prefixes, tags each event
//  make/break and extended/normal, and buffers events in a FIFO with a
//  valid/ready port. Sits between the PS/2 receive datapath and the key consumer.
// PARAMETERS
//  DEPTH        8        event FIFO entries; power of 2, >=2
//  TIMEOUT_CYC  100000   Clk cycles a prefix state may wait for its next byte
// PORTS
//  Clk          in   1   system clock; everything on posedge
//  Reset        in   1   asynchronous, active-low reset
//  NewScanCode  in   1   1-cycle pulse: ScanCode holds a new byte
//  ScanCode     in   8   received byte, sampled when NewScanCode=1
//  EvValid      out  1   FIFO head event valid
//  EvReady      in   1   consumer accepts head event
//  EvCode       out  8   head event scan code, prefix bytes removed
//  EvBreak      out  1   head event is a break (key release)
//  EvExt        out  1   head event carried the E0 prefix
//  EvCount      out  $clog2(DEPTH)+1  number of FIFO entries
//  Overflow     out  1   sticky: an event was dropped because the FIFO was full
//  ClrOverflow  in   1   clears Overflow (set takes priority in the same cycle)
//  ErrPulse     out  1   1-cycle pulse: error byte 00/FF received
// BEHAVIOUR
//  Reset (Reset=0): FSM=IDLE, FIFO empty, timeout counter=0, EvValid=0,
//   EvCode=0, EvBreak=0, EvExt=0, EvCount=0, Overflow=0, ErrPulse=0.
//   The reset is asynchronous: it aborts any prefix sequence in progress and
//   discards the FIFO contents.
//  FSM runs only on NewScanCode=1. States and transitions:
//   IDLE:    E0->EXT; F0->BRK; otherwise emit(make, ext=0), stay IDLE
//   EXT:     F0->EXT_BRK; E0->EXT; otherwise emit(make, ext=1)->IDLE
//   BRK:     E0->EXT_BRK; F0->BRK; otherwise emit(break, ext=0)->IDLE
//   EXT_BRK: E0/F0->EXT_BRK; otherwise emit(break, ext=1)->IDLE
//  Error bytes 00 and FF, in any state: no event, ->IDLE, ErrPulse=1 for the next cycle.
//  Timeout: when the FSM is not in IDLE, a counter increments each cycle with
//   NewScanCode=0. Any byte clears the counter. When the counter reaches
//   TIMEOUT_CYC-1, the FSM goes to IDLE, no event is emitted, and the counter clears.
//  Emit = FIFO push of {code, break, ext}, registered on the Clk edge that samples
//   the byte. Latency: with the FIFO empty, EvValid=1 the cycle after the NewScanCode pulse.
//  FIFO:
//   - EvValid = (EvCount != 0).
//   - EvCode/EvBreak/EvExt show the head entry; they are 0 when the FIFO is empty.
//   - Pop on EvValid & EvReady.
//   - Pointers wrap modulo DEPTH.
//   - Push while full and no pop: event dropped, Overflow<=1, count unchanged.
//   - Push and pop in the same cycle while full: both happen, no overflow.
//   - Push and pop in the same cycle while empty: the push is stored; nothing is
//     popped (EvValid was 0).
//  EvReady while EvValid=0 is ignored. The head entry is stable while
//   EvValid=1 and EvReady=0.
// CONFIGURATION
//  TYPEMATIC_FILTER_EN defined:
//   - A held-key register {valid, code, ext} suppresses typematic repeats.
//   - A make equal to the held key pushes no event and does not set Overflow.
//   - Any other make pushes and replaces the held key.
//   - A break matching the held key pushes and clears the held key.
//   - Reset clears the held key.
//  TYPEMATIC_FILTER_EN undefined: every make is pushed. The held-key register
//   is not built.
// TESTING
//  T1 bytes 1C; F0,1C -> events {1C,make,ext0}, {1C,brk,ext0}; EvValid the cycle
//     after the 1C pulse
//  T2 bytes E0,75; E0,F0,75 -> {75,make,ext1}, {75,brk,ext1}; no event for
//     prefix bytes
//  T3 EvReady=0, 9 makes with DEPTH=8 -> EvCount=8, Overflow=1, first 8 codes
//     drain in order; ClrOverflow -> Overflow=0
//  T4 byte E0, then idle TIMEOUT_CYC cycles, then 1C -> {1C,make,ext0};
//     byte FF -> ErrPulse, no event
//  T5 FIFO full with EvReady=1 and push in the same cycle -> EvCount stays 8,
//     Overflow=0; Reset low mid-sequence after F0 -> all outputs 0, next 1C is a make
//  T6 TYPEMATIC_FILTER_EN: 1C,1C,1C,F0,1C -> only {1C,make}, {1C,brk};
//     without the macro -> 3 makes and 1 break

Source files
------------

// File: rtl/scan_code_event_ctrl.sv
// scan_code_event_ctrl: turns PS/2 scan bytes into make/break, normal/extended key events queued in a FIFO.
// Optional macro TYPEMATIC_FILTER_EN suppresses typematic repeats of the currently held key.
module scan_code_event_ctrl #(
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   NewScanCode,
  input  logic [7:0]             ScanCode,
  output logic                   EvValid,
  input  logic                   EvReady,
  output logic [7:0]             EvCode,
  output logic                   EvBreak,
  output logic                   EvExt,
  output logic [$clog2(DEPTH):0] EvCount,
  output logic                   Overflow,
  input  logic                   ClrOverflow,
  output logic                   ErrPulse,
  output logic [1:0]             DbgState
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYC - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  state_t          r_state, w_next;
  logic [CW-1:0]   r_tcnt;
  logic            w_is_e0, w_is_f0, w_is_err;
  logic            w_emit, w_brk, w_ext, w_err, w_push;
  logic            r_err;

  assign w_is_e0  = (ScanCode == 8'hE0);
  assign w_is_f0  = (ScanCode == 8'hF0);
  assign w_is_err = (ScanCode == 8'h00) || (ScanCode == 8'hFF);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_emit = 1'b0;
    w_brk  = 1'b0;
    w_ext  = 1'b0;
    w_err  = 1'b0;
    if (NewScanCode) begin
      if (w_is_err) begin
        w_err  = 1'b1;
        w_next = S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_is_e0)      w_next = S_EXT;
            else if (w_is_f0) w_next = S_BRK;
            else              w_emit = 1'b1;
          end
          S_EXT: begin
            if (w_is_f0)      w_next = S_EXT_BRK;
            else if (w_is_e0) w_next = S_EXT;
            else begin
              w_emit = 1'b1; w_ext = 1'b1; w_next = S_IDLE;
            end
          end
          S_BRK: begin
            if (w_is_e0)      w_next = S_EXT_BRK;
            else if (w_is_f0) w_next = S_BRK;
            else begin
              w_emit = 1'b1; w_brk = 1'b1; w_next = S_IDLE;
            end
          end
          default: begin
            if (!(w_is_e0 || w_is_f0)) begin
              w_emit = 1'b1; w_brk = 1'b1; w_ext = 1'b1; w_next = S_IDLE;
            end
          end
        endcase
      end
    end else if (r_state != S_IDLE && r_tcnt == TO_LAST) begin
      w_next = S_IDLE;
    end
  end

  // Counts quiet cycles inside a prefix sequence; any byte or a return to IDLE restarts it.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)                                                r_tcnt <= '0;
    else if (NewScanCode || r_state == S_IDLE || r_tcnt == TO_LAST) r_tcnt <= '0;
    else                                                       r_tcnt <= r_tcnt + CW'(1);
  end

`ifdef TYPEMATIC_FILTER_EN
  logic       r_held_v;
  logic [7:0] r_held_code;
  logic       r_held_ext;
  logic       w_held_match;

  assign w_held_match = r_held_v && (r_held_code == ScanCode) && (r_held_ext == w_ext);
  assign w_push       = w_emit && !(w_held_match && !w_brk);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_held_v    <= 1'b0;
      r_held_code <= 8'h00;
      r_held_ext  <= 1'b0;
    end else if (w_emit && !w_brk) begin
      r_held_v    <= 1'b1;
      r_held_code <= ScanCode;
      r_held_ext  <= w_ext;
    end else if (w_emit && w_held_match) begin
      r_held_v    <= 1'b0;
    end
  end
`else
  assign w_push = w_emit;
`endif

  // Event port: the head is offered while EvValid=1 and is consumed on any edge with
  // EvValid & EvReady; EvReady with EvValid=0 has no effect.
  logic [9:0]    r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr, r_wr_ptr;
  logic [AW:0]   r_count;
  logic          w_pop, w_full, w_wr, w_drop;

  assign w_pop  = EvValid && EvReady;
  assign w_full = (r_count == FULL_CNT);
  assign w_wr   = w_push && (!w_full || w_pop);
  assign w_drop = w_push && w_full && !w_pop;

  always_ff @(posedge Clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= {ScanCode, w_brk, w_ext};
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      Overflow <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop)           Overflow <= 1'b1;
      else if (ClrOverflow) Overflow <= 1'b0;
      r_err <= w_err;
    end
  end

  assign EvValid                 = (r_count != '0);
  assign {EvCode, EvBreak, EvExt} = EvValid ? r_mem[r_rd_ptr] : 10'd0;
  assign EvCount                 = r_count;
  assign ErrPulse                = r_err;
  assign DbgState                = r_state;
endmodule

// File: tb/tb_scan_code_event_ctrl.sv
// Self-checking bench for scan_code_event_ctrl: event-level model plus directed byte sequences.
module tb_scan_code_event_ctrl;
  localparam int DEPTH = 8;
  localparam int TO    = 16;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       NewScanCode = 1'b0;
  logic [7:0] ScanCode = 8'h00;
  logic       EvReady = 1'b0;
  logic       ClrOverflow = 1'b0;
  logic       EvValid, EvBreak, EvExt, Overflow, ErrPulse;
  logic [7:0] EvCode;
  logic [3:0] EvCount;
  logic [1:0] DbgState;

  int n_checks = 0;
  int n_errors = 0;

  scan_code_event_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
    .Clk(Clk), .Reset(Reset), .NewScanCode(NewScanCode), .ScanCode(ScanCode),
    .EvValid(EvValid), .EvReady(EvReady), .EvCode(EvCode), .EvBreak(EvBreak),
    .EvExt(EvExt), .EvCount(EvCount), .Overflow(Overflow), .ClrOverflow(ClrOverflow),
    .ErrPulse(ErrPulse), .DbgState(DbgState)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: pending prefix flags, quiet-cycle count, expected event queue {code,brk,ext}.
  logic [9:0] exp_q[$];
  bit         m_ext, m_brk, m_ovf, m_err;
  int         m_quiet;
`ifdef TYPEMATIC_FILTER_EN
  bit         m_held_v;
  logic [8:0] m_held;
`endif

  task automatic model_step();
    bit         pop, push, drop;
    logic [9:0] ev;
    if (!Reset) begin
      exp_q.delete();
      m_ext = 0; m_brk = 0; m_ovf = 0; m_err = 0; m_quiet = 0;
`ifdef TYPEMATIC_FILTER_EN
      m_held_v = 0;
`endif
      return;
    end
    pop  = (exp_q.size() != 0) && EvReady;
    push = 0;
    drop = 0;
    ev   = '0;
    m_err = 0;
    if (NewScanCode) begin
      m_quiet = 0;
      if (ScanCode == 8'h00 || ScanCode == 8'hFF) begin
        m_err = 1; m_ext = 0; m_brk = 0;
      end else if (ScanCode == 8'hE0) m_ext = 1;
      else if (ScanCode == 8'hF0) m_brk = 1;
      else begin
        ev = {ScanCode, m_brk, m_ext};
        push = 1; m_ext = 0; m_brk = 0;
      end
    end else if (m_ext || m_brk) begin
      m_quiet++;
      if (m_quiet == TO) begin
        m_ext = 0; m_brk = 0; m_quiet = 0;
      end
    end
`ifdef TYPEMATIC_FILTER_EN
    if (push) begin
      if (!ev[1]) begin
        if (m_held_v && m_held == {ev[9:2], ev[0]}) push = 0;
        else begin m_held_v = 1; m_held = {ev[9:2], ev[0]}; end
      end else if (m_held_v && m_held == {ev[9:2], ev[0]}) m_held_v = 0;
    end
`endif
    if (push && exp_q.size() == DEPTH && !pop) drop = 1;
    if (pop) void'(exp_q.pop_front());
    if (push && !drop) exp_q.push_back(ev);
    if (drop) m_ovf = 1;
    else if (ClrOverflow) m_ovf = 0;
  endtask

  task automatic compare();
    logic [9:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : 10'd0;
    check("ev_valid", 32'(EvValid), 32'(exp_q.size() != 0));
    check("ev_count", 32'(EvCount), 32'(exp_q.size()));
    check("ev_head", 32'({EvCode, EvBreak, EvExt}), 32'(head));
    check("overflow", 32'(Overflow), 32'(m_ovf));
    check("err_pulse", 32'(ErrPulse), 32'(m_err));
  endtask

  initial forever begin
    @(posedge Clk);
    model_step();
  end

  initial forever begin
    @(negedge Clk);
    if (Reset) compare();
  end

  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    NewScanCode = 1'b1;
    ScanCode    = b;
    tick();
    NewScanCode = 1'b0;
    ScanCode    = 8'h00;
  endtask

  task automatic pop_one();
    EvReady = 1'b1;
    tick();
    EvReady = 1'b0;
  endtask

  task automatic drain();
    EvReady = 1'b1;
    repeat (DEPTH + 2) tick();
    EvReady = 1'b0;
  endtask

  task automatic check_head(input string nm, input logic [7:0] c, input logic b, input logic e);
    check(nm, 32'({EvCode, EvBreak, EvExt}), 32'({c, b, e}));
  endtask

  initial begin
    repeat (3) tick();
    check("rst_valid", 32'(EvValid), 32'd0);
    check("rst_count", 32'(EvCount), 32'd0);
    check("rst_head", 32'({EvCode, EvBreak, EvExt}), 32'd0);
    check("rst_ovf_err", 32'({Overflow, ErrPulse}), 32'd0);
    check("rst_state", 32'(DbgState), 32'd0);
    Reset = 1'b1;
    tick();

    // T1: plain make, then break
    send_byte(8'h1C);
    check("t1_latency", 32'(EvValid), 32'd1);
    check_head("t1_make", 8'h1C, 1'b0, 1'b0);
    send_byte(8'hF0);
    send_byte(8'h1C);
    check("t1_count", 32'(EvCount), 32'd2);
    pop_one();
    check_head("t1_break", 8'h1C, 1'b1, 1'b0);
    pop_one();
    check("t1_empty", 32'(EvValid), 32'd0);

    // T2: extended make and break, prefixes produce nothing
    send_byte(8'hE0);
    check("t2_prefix_silent", 32'(EvValid), 32'd0);
    send_byte(8'h75);
    check_head("t2_ext_make", 8'h75, 1'b0, 1'b1);
    send_byte(8'hE0);
    send_byte(8'hF0);
    check("t2_count_prefix", 32'(EvCount), 32'd1);
    send_byte(8'h75);
    pop_one();
    check_head("t2_ext_break", 8'h75, 1'b1, 1'b1);
    pop_one();

    // T3: overflow with nine makes, ordered drain, clear
    for (int i = 0; i < 9; i++) send_byte(8'h10 + 8'(i));
    check("t3_count_full", 32'(EvCount), 32'd8);
    check("t3_overflow", 32'(Overflow), 32'd1);
    for (int i = 0; i < 8; i++) begin
      check_head("t3_order", 8'h10 + 8'(i), 1'b0, 1'b0);
      pop_one();
    end
    check("t3_ovf_sticky", 32'(Overflow), 32'd1);
    ClrOverflow = 1'b1;
    tick();
    ClrOverflow = 1'b0;
    check("t3_ovf_clear", 32'(Overflow), 32'd0);

    // T4: prefix timeout, prefix survives short gap, error bytes
    send_byte(8'hE0);
    repeat (TO) tick();
    send_byte(8'h1C);
    check_head("t4_timeout", 8'h1C, 1'b0, 1'b0);
    pop_one();
    send_byte(8'hE0);
    repeat (3) tick();
    send_byte(8'h1C);
    check_head("t4_short_gap", 8'h1C, 1'b0, 1'b1);
    pop_one();
    send_byte(8'hFF);
    check("t4_err_pulse", 32'(ErrPulse), 32'd1);
    check("t4_err_no_event", 32'(EvValid), 32'd0);
    tick();
    check("t4_err_one_cycle", 32'(ErrPulse), 32'd0);
    send_byte(8'hF0);
    send_byte(8'h00);
    send_byte(8'h1C);
    check_head("t4_err_aborts", 8'h1C, 1'b0, 1'b0);
    drain();

    // T5: push and pop together while full, then async reset mid-sequence
    for (int i = 0; i < 8; i++) send_byte(8'h30 + 8'(i));
    EvReady = 1'b1;
    send_byte(8'h38);
    EvReady = 1'b0;
    check("t5_count_full", 32'(EvCount), 32'd8);
    check("t5_no_overflow", 32'(Overflow), 32'd0);
    check_head("t5_head", 8'h31, 1'b0, 1'b0);
    send_byte(8'hF0);
    #2 Reset = 1'b0;
    #1;
    check("t5_async_valid", 32'(EvValid), 32'd0);
    check("t5_async_count", 32'(EvCount), 32'd0);
    check("t5_async_head", 32'({EvCode, EvBreak, EvExt}), 32'd0);
    check("t5_async_state", 32'(DbgState), 32'd0);
    tick();
    Reset = 1'b1;
    tick();
    send_byte(8'h1C);
    check_head("t5_post_reset", 8'h1C, 1'b0, 1'b0);
    send_byte(8'hF0);
    send_byte(8'h1C);
    drain();

    // T6: typematic repeats
    send_byte(8'h1C);
    send_byte(8'h1C);
    send_byte(8'h1C);
    send_byte(8'hF0);
    send_byte(8'h1C);
`ifdef TYPEMATIC_FILTER_EN
    check("t6_count", 32'(EvCount), 32'd2);
`else
    check("t6_count", 32'(EvCount), 32'd4);
`endif
    check_head("t6_first", 8'h1C, 1'b0, 1'b0);
    drain();
    check("t6_empty", 32'(EvValid), 32'd0);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
